bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter (shift-and-add-3), one bit per clock.
//  Replaces the combinational converter wherever binary width or digit count grows
//  (score, timer, length counters feeding the 7-seg/VGA text path), trading latency for area.
//  Adds a start/busy/done handshake, an overflow flag and a leading-zero blanking mask.
// PARAMETERS
//  BIN_W   16  width of binary input, >= 1
//  DIGITS   5  number of BCD digits produced, >= 1; need not cover the full BIN_W range
// PORTS
//  clk     in   1          system clock, all logic on rising edge
//  rst_n   in   1          asynchronous active-low reset
//  start   in   1          request a conversion; sampled only in IDLE
//  bin     in   BIN_W      binary operand; captured on the accepted start cycle
//  busy    out  1          high from the cycle after accept until done is asserted
//  done    out  1          one-cycle pulse: bcd/ovf/blank updated this cycle
//  bcd     out  4*DIGITS   result, digit k at [4k+3:4k], digit 0 = LSD
//  ovf     out  1          result did not fit: bcd holds bin mod 10**DIGITS
//  blank   out  DIGITS     blank[k]=1: digit k is a leading zero (blank[0] always 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, ovf=0, bcd=0, blank={DIGITS-1{1'b1},1'b0}.
//  Reset mid-conversion aborts: no done pulse, outputs return to reset values.
//  FSM: IDLE -> SHIFT on start; SHIFT -> DONE when bit counter reaches 0; DONE -> IDLE.
//  Accept (IDLE & start): shift reg <= bin, accumulator <= 0, cnt <= BIN_W-1, ovf_acc <= 0.
//  SHIFT, each cycle: every 4-bit accumulator digit >4 gets +3 (all digits in parallel),
//   then {acc, sreg} shifted left by 1; MSB of sreg enters acc digit 0;
//   bit shifted out of top digit ORed into ovf_acc; cnt decrements.
//  After exactly BIN_W SHIFT cycles go to DONE: bcd<=acc, ovf<=ovf_acc, blank computed,
//   done=1 for that single cycle. Latency: start accepted cycle N -> done at cycle N+BIN_W+1.
//  Outputs bcd/ovf/blank hold between done pulses; never change while busy.
//  start while busy or in DONE is ignored (not queued); start in same cycle done is high is
//   ignored; next accept earliest the cycle after done. bin changes after accept have no effect.
//  blank: scan from digit DIGITS-1 down to 1; blank[k]=1 while all digits >=k are zero.
//  ovf arithmetic: truncation of the add-3 chain yields exactly bin mod 10**DIGITS.
//  Counter width $clog2(BIN_W+1); BIN_W=1 must work (single SHIFT cycle).
// STRUCTURE
//  Shared package bcd_pkg: BCD_DIGIT_W=4, state encoding (IDLE/SHIFT/DONE) as localparams,
//   function for minimum digit count ceil(BIN_W*log10 2) used by integrators.
//  Sub-module bcd_digit_adj: combinational 4-bit "if >4 add 3"; generate DIGITS instances.
//  Top holds FSM, bit counter, shift register, accumulator, output registers.
// TESTING
//  BIN_W=16,DIGITS=5, bin=65535 -> done 17 cycles after accept, bcd=6_5_5_3_5, ovf=0, blank=00000.
//  bin=0 -> bcd=0_0_0_0_0, ovf=0, blank=11110; bin=7 -> bcd=0_0_0_0_7, blank=11110.
//  DIGITS=3, bin=1234 -> bcd=2_3_4, ovf=1; bin=999 -> bcd=9_9_9, ovf=0.
//  start held high continuously, bin=42 then 1000 -> conversions back-to-back, one done each,
//   no start accepted while busy or on the done cycle; second result 0_1_0_0_0.
//  rst_n pulsed low mid-SHIFT (cycle 8 of 16) -> busy=0, no done, outputs at reset values;
//   next start converts correctly.
//  Random bin over 10k runs, BIN_W in {1,8,16,20} -> compare to integer model incl. ovf/blank.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   BCD_DIGIT_W         width of one packed BCD digit
//   ST_IDLE/SHIFT/DONE  converter state encodings
//   state_t             enum built on those encodings
//   min_digits()        digits needed to show every BIN_W-bit value, i.e. ceil(bin_w*log10(2))
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

   // log10(2) ~= 0.30103. The error is about 4e-9 per bit, so the result is exact
   // for any practical width.
   function automatic int min_digits(input int bin_w);
      return (bin_w * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One digit of the double-dabble correction: if the digit is above 4, add 3.
// This runs before each left shift, so a digit of 5..9 carries into the next digit.
//   din   in  4  BCD digit before correction
//   dout  out 4  corrected digit
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (din > 4'd4) dout = din + 4'd3;
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3. It converts one bit per clock.
//   clk    in   1         system clock, rising edge
//   rst_n  in   1         asynchronous active-low reset
//   start  in   1         conversion request, sampled in IDLE only
//   bin    in   BIN_W     operand, captured on the cycle start is accepted
//   busy   out  1         conversion in progress
//   done   out  1         one-cycle pulse; bcd/ovf/blank were updated this cycle
//   bcd    out  4*DIGITS  result, digit 0 = least significant
//   ovf    out  1         the value did not fit; bcd holds bin mod 10**DIGITS
//   blank  out  DIGITS    leading-zero mask, blank[0] is always 0
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one adjust+shift per cycle, cnt counts down to terminal 0
// DONE  | done pulse; result registers were loaded on entry
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          ovf,
   output logic [DIGITS-1:0]             blank
);

   localparam int ACC_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [BIN_W-1:0]   sreg;
   logic [ACC_W-1:0]   acc, acc_adj, acc_nxt;
   logic               ovf_acc, ovf_nxt;
   logic               accept, last;
   logic [DIGITS-1:0]  blank_nxt;
   logic               seen_nz;

   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (acc[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
         .dout (acc_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
      );
   end

   // The bit shifted out of the top digit is lost. Any such loss means the value did not fit.
   assign acc_nxt = {acc_adj[ACC_W-2:0], sreg[BIN_W-1]};
   assign ovf_nxt = ovf_acc | acc_adj[ACC_W-1];

   always_comb begin
      blank_nxt = '0;
      seen_nz   = 1'b0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         seen_nz      = seen_nz | (acc_nxt[BCD_DIGIT_W*k +: BCD_DIGIT_W] != '0);
         blank_nxt[k] = ~seen_nz;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == '0) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg    <= '0;
         acc     <= '0;
         cnt     <= '0;
         ovf_acc <= 1'b0;
      end else if (accept) begin
         sreg    <= bin;
         acc     <= '0;
         cnt     <= CNT_W'(BIN_W - 1);
         ovf_acc <= 1'b0;
      end else if (state == SHIFT) begin
         sreg    <= sreg << 1;
         acc     <= acc_nxt;
         ovf_acc <= ovf_nxt;
         cnt     <= cnt - CNT_W'(1);
      end
   end

   // The result registers load on the final shift edge, so they are valid during the DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd   <= '0;
         ovf   <= 1'b0;
         blank <= BLANK_RST;
      end else if (last) begin
         bcd   <= acc_nxt;
         ovf   <= ovf_nxt;
         blank <= blank_nxt;
      end
   end

endmodule
